// File: rtl/bcd_countdown_timer.sv
// Packed-BCD mm:ss down-counter with load/start/pause control, seconds borrow
// and expiry signalling. Drives the shared BCD display path.
module bcd_countdown_timer #(
  parameter logic [7:0] MAX_MIN = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       running,
  output logic       sec_borrow,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t     state;
  logic       load_valid;
  logic       is_zero;
  logic       wrap;
  logic       reach_zero;
  logic [7:0] dec_min;
  logic [7:0] dec_sec;

  // Seconds tens only ever reach 5, so a valid-digit check plus tens<=5 covers <=59.
  assign load_valid = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                      (load_min <= MAX_MIN);

  assign is_zero    = (minutes == 8'h00) && (seconds == 8'h00);
  assign reach_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);
  assign running    = (state == RUN);
  assign expired    = (state == EXPIRED);

  always_comb begin
    dec_min = minutes;
    dec_sec = seconds;
    wrap    = 1'b0;
    if (seconds[3:0] != 4'd0) begin
      dec_sec[3:0] = seconds[3:0] - 4'd1;
    end else if (seconds[7:4] != 4'd0) begin
      dec_sec = {seconds[7:4] - 4'd1, 4'd9};
    end else begin
      // Never entered with minutes at 00: RUN always expires at 00:00 first.
      dec_sec = 8'h59;
      wrap    = 1'b1;
      if (minutes[3:0] != 4'd0) begin
        dec_min[3:0] = minutes[3:0] - 4'd1;
      end else begin
        dec_min = {minutes[7:4] - 4'd1, 4'd9};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      minutes    <= 8'h00;
      seconds    <= 8'h00;
      sec_borrow <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      sec_borrow <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
      if (load) begin
        if (load_valid) begin
          minutes <= load_min;
          seconds <= load_sec;
          state   <= IDLE;
        end else begin
          load_err <= 1'b1;
        end
      end else if (pause) begin
        if (state == RUN) state <= PAUSE;
      end else if (start) begin
        if ((state == IDLE || state == PAUSE) && !is_zero) state <= RUN;
      end else if (tick && state == RUN) begin
        minutes    <= dec_min;
        seconds    <= dec_sec;
        sec_borrow <= wrap;
        if (reach_zero) begin
          state <= EXPIRED;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Packed-BCD minutes:seconds down-counter for the timer datapath: the decrementing counterpart of the mod-60 BCD up-counter. It loads a preset mm:ss, counts down one second per `tick` enable, and signals a borrow on every 00→59 seconds wrap. It pulses `done` and holds `expired` when it reaches 00:00. It sits beside the up-counting clock chain and drives the same BCD display path.

## Interface
- `MAX_MIN`, default 8'h99: largest loadable minutes value (packed BCD).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle count enable (nominally 1 Hz strobe); a level held high counts on every cycle.
- `load`  in  1  load `load_min`/`load_sec` this cycle.
- `load_min`  in  8  preset minutes, packed BCD [7:4] tens, [3:0] units.
- `load_sec`  in  8  preset seconds, packed BCD.
- `start`  in  1  begin or resume counting.
- `pause`  in  1  suspend counting.
- `minutes`  out  8  current minutes, packed BCD.
- `seconds`  out  8  current seconds, packed BCD.
- `running`  out  1  high in RUN.
- `sec_borrow`  out  1  one-cycle pulse on each seconds 00→59 wrap.
- `done`  out  1  one-cycle pulse on the transition to 00:00.
- `expired`  out  1  level, high in EXPIRED.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. `running` = (state==RUN). `expired` = (state==EXPIRED).
- Per-cycle priority is `load` > `pause` > `start` > `tick`. Exactly one action is taken per cycle.
- Load:
  - A load is valid when every nibble is ≤9, `load_sec` ≤ 8'h59 and `load_min` ≤ MAX_MIN.
  - A valid load updates `minutes`/`seconds` and sends any state to IDLE.
  - An invalid load leaves the value and state unchanged and pulses `load_err`.
- `start`:
  - From IDLE or PAUSE, goes to RUN when the value is ≠ 00:00.
  - Ignored when the value is 00:00.
  - Ignored in RUN and EXPIRED.
- `pause`: RUN→PAUSE. Ignored in other states.
- `tick` in RUN decrements by one second:
  - Seconds units ≠0: units −1.
  - Seconds units = 0, tens ≠0: units←9, tens −1.
  - Seconds = 00: seconds←8'h59, minutes BCD-decremented (units 0 → 9 with tens −1), `sec_borrow`=1.
  - Result = 00:00: state←EXPIRED, `done`=1 in the same cycle as the value update.
- `tick` outside RUN has no effect.
- EXPIRED holds 00:00 until a valid `load`. `start` does not leave EXPIRED.
- All arithmetic is nibble-wise BCD. No binary carry may ever propagate into a tens nibble, and no nibble may ever hold A–F.

## Timing
- Reset (asynchronous, active-low) forces:
  - state←IDLE, `minutes`=8'h00, `seconds`=8'h00;
  - `running`, `sec_borrow`, `done`, `expired` and `load_err` all 0.
- Reset asserted mid-count aborts immediately, with no `done` pulse. After release the block waits in IDLE for a load.
- Outputs are registered. The value changes on the rising edge at which `tick` is sampled high in RUN, so latency is 1 clock.
- `start` sampled at edge N: RUN from N. A `tick` at N+1 is the first to decrement. A `tick` coincident with `start` is not counted.
- `pause` coincident with `tick`: no decrement.
- `load` coincident with `tick`: the load wins and the decrement is dropped.
- Pulses (`sec_borrow`, `done`, `load_err`) are high for exactly one cycle, the cycle after the causing edge. They are low otherwise.
- On the 01:00→00:59 step, `sec_borrow` fires.
- On the 00:01→00:00 step, `done` fires and `sec_borrow` does not.

## Test plan
- Reset then load 8'h01/8'h00, start, 1 tick → 00:59, `sec_borrow` pulse, `running`=1.
- Load 8'h00/8'h03, start, 3 ticks:
  - values 00:02, 00:01, 00:00;
  - `done` pulse on the third tick, `expired`=1, `running`=0;
  - further ticks and a `start` leave 00:00/EXPIRED.
- Load 8'h10/8'h00, start, 1 tick → 09:59: minutes tens/units borrow correct, no A–F nibble.
- Load 8'h00/8'h60 → `load_err` pulse, value unchanged.
- Load 8'h1A/8'h00 → `load_err` pulse, value unchanged.
- Load 8'h05/8'h30, start, tick, pause, 5 ticks → holds 05:29. Then start, tick → 05:28.
- Mid-count: reset low asynchronously between edges → outputs 0 immediately, no `done`. Simultaneous `load`+`tick` in RUN → loaded value, state IDLE.
